// File: rtl/mult_result_sink.sv
// Result sink for the mult_tree pipeline: delays i_valid to line up with the
// product, then queues products in a FIFO with drop accounting when full.
module mult_result_sink #(
  parameter int LATENCY = 3,
  parameter int DEPTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  input  logic [7:0]               i_result,
  output logic                     o_valid,
  output logic [7:0]               o_data,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic [7:0]               o_drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [LATENCY-1:0] vld_sr;
  logic               wr_req;
  logic               wr_en;
  logic               rd_en;
  logic               drop;
  logic [7:0]         mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;

  generate
    if (LATENCY == 1) begin : g_lat1
      always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_sr <= '0;
        else     vld_sr <= i_valid;
      end
    end else begin : g_latn
      always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_sr <= '0;
        else     vld_sr <= {vld_sr[LATENCY-2:0], i_valid};
      end
    end
  endgenerate

  assign wr_req = vld_sr[LATENCY-1];
  assign rd_en  = o_valid & i_ready;
  // A read in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr_en  = wr_req & ((count != FULL) | rd_en);
  assign drop   = wr_req & ~wr_en;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= i_result;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        o_overflow <= 1'b1;
        if (o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 1'b1;
      end
    end
  end

  assign o_count = count;
  assign o_valid = (count != '0);
  // Storage is never cleared, so mask it whenever the FIFO is empty.
  assign o_data  = o_valid ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_mult_result_sink.sv
// Directed bench for mult_result_sink; a small model of mult_tree latency
// presents each product LATENCY cycles after its i_valid.
module tb_mult_result_sink;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid;
  logic [7:0] i_result;
  logic       o_valid;
  logic [7:0] o_data;
  logic       i_ready;
  logic [3:0] o_count;
  logic       o_overflow;
  logic [7:0] o_drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] pv [4];
  int issued;
  int nread;

  mult_result_sink #(.LATENCY(3), .DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_result   (i_result),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .i_ready    (i_ready),
    .o_count    (o_count),
    .o_overflow (o_overflow),
    .o_drop_cnt (o_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle and drive that cycle's inputs.
  task automatic cyc(input logic v, input logic [7:0] r, input logic rdy);
    @(posedge clk);
    #1;
    pv[3] = pv[2];
    pv[2] = pv[1];
    pv[1] = pv[0];
    pv[0] = v ? r : 8'hEE;
    i_valid  = v;
    i_ready  = rdy;
    i_result = pv[3];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b1, 8'h55, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_result = 8'h00;
    for (int i = 0; i < 4; i++) pv[i] = 8'h00;

    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_data", o_data, 8'h00);
    chk("rst_count", o_count, 4'd0);
    chk("rst_ovf", o_overflow, 1'b0);
    chk("rst_drop", o_drop_cnt, 8'd0);
    rst = 1'b0;

    // latency: i_valid at cycle 0, visible from cycle 4
    cyc(1'b1, 8'h5A, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0);
    chk("lat_c3_valid", o_valid, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("lat_c4_valid", o_valid, 1'b1);
    chk("lat_c4_data", o_data, 8'h5A);
    chk("lat_c4_count", o_count, 4'd1);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("lat_drain_valid", o_valid, 1'b0);
    chk("lat_drain_data", o_data, 8'h00);

    // simultaneous read and write at count 1
    cyc(1'b1, 8'h3C, 1'b0);
    cyc(1'b1, 8'hC3, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("rw1_head", o_data, 8'h3C);
    cyc(1'b0, 8'h00, 1'b0);
    chk("rw1_count", o_count, 4'd1);
    chk("rw1_data", o_data, 8'hC3);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("empty_ready_count", o_count, 4'd0);
    chk("empty_ready_valid", o_valid, 1'b0);

    // fill and overflow with results 1..9
    for (int k = 1; k <= 9; k++) cyc(1'b1, 8'(k), 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0);
    chk("fill_count", o_count, 4'd8);
    chk("fill_ovf", o_overflow, 1'b1);
    chk("fill_drop", o_drop_cnt, 8'd1);
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("fill_order", o_data, 32'(k));
    end
    cyc(1'b0, 8'h00, 1'b0);
    chk("fill_empty", o_valid, 1'b0);
    chk("fill_ovf_sticky", o_overflow, 1'b1);

    // full FIFO with concurrent read as 0xA0 arrives
    for (int k = 0; k < 8; k++) cyc(1'b1, 8'(8'h10 + k), 1'b0);
    cyc(1'b1, 8'hA0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("fullrw_pre_count", o_count, 4'd8);
    chk("fullrw_pre_head", o_data, 8'h10);
    cyc(1'b0, 8'h00, 1'b0);
    chk("fullrw_count", o_count, 4'd8);
    chk("fullrw_drop", o_drop_cnt, 8'd1);
    chk("fullrw_head", o_data, 8'h11);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("fullrw_order", o_data, (k < 7) ? 32'(8'h11 + k) : 32'hA0);
    end
    cyc(1'b0, 8'h00, 1'b0);
    chk("fullrw_empty", o_valid, 1'b0);

    // wrap-around stream with i_ready toggling
    do_reset();
    chk("wrap_rst_ovf", o_overflow, 1'b0);
    chk("wrap_rst_drop", o_drop_cnt, 8'd0);
    chk("wrap_rst_count", o_count, 4'd0);
    issued = 0;
    nread  = 0;
    for (int c = 0; c < 60; c++) begin
      if ((c % 2 == 0) && (issued < 20)) begin
        cyc(1'b1, 8'(8'h40 + issued), 1'(c % 2 == 0));
        issued++;
      end else begin
        cyc(1'b0, 8'h00, 1'(c % 2 == 0));
      end
      if (o_valid && i_ready) begin
        chk("wrap_order", o_data, 32'(8'h40 + nread));
        nread++;
      end
    end
    chk("wrap_nread", nread, 20);
    chk("wrap_ovf", o_overflow, 1'b0);
    chk("wrap_count", o_count, 4'd0);

    // drop counter saturation
    do_reset();
    for (int k = 0; k < 308; k++) cyc(1'b1, 8'(k + 1), 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0);
    chk("sat_count", o_count, 4'd8);
    chk("sat_drop", o_drop_cnt, 8'd255);
    chk("sat_ovf", o_overflow, 1'b1);
    chk("sat_head", o_data, 8'h01);

    // asynchronous reset with results in flight
    do_reset();
    for (int k = 0; k < 9; k++) cyc(1'b1, 8'(8'h80 + k), 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0);
    chk("mid_pre_count", o_count, 4'd8);
    chk("mid_pre_ovf", o_overflow, 1'b1);
    cyc(1'b1, 8'h71, 1'b0);
    cyc(1'b1, 8'h72, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk("mid_async_valid", o_valid, 1'b0);
    chk("mid_async_data", o_data, 8'h00);
    chk("mid_async_count", o_count, 4'd0);
    chk("mid_async_ovf", o_overflow, 1'b0);
    chk("mid_async_drop", o_drop_cnt, 8'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 8'h00, 1'b0);
      chk("mid_no_valid", o_valid, 1'b0);
    end
    chk("mid_count", o_count, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
